led_sequencer: RTL
==================

# led_sequencer

Parametrised LED pattern sequencer that drives NUM_LEDS outputs from one free-running prescaler. It supports four run-time selectable patterns: walk-up, walk-down, bounce and all-flash. It also provides a wrapping lap counter and per-step and per-lap pulses. It sits at the board-level I/O edge in place of the fixed three-LED blinker and generalises LED count, step period and pattern.

## Interface
- NUM_LEDS, 3: number of LED outputs; legal range is 2 or more.
- TICK_CYCLES, 100000000: clock cycles per pattern step (1 s at 100 MHz); legal range is 1 or more.
- CNT_W, 8: width of lap_count.
- clk  input  1  system clock; all logic on its rising edge.
- reest  input  1  synchronous, active-low reset, sampled on rising clk.
- enable  input  1  high: prescaler runs; low: prescaler and pattern freeze.
- mode  input  2  pattern select: 00 walk-up, 01 walk-down, 10 bounce, 11 all-flash.
- leds  output  NUM_LEDS  LED drive, registered.
- step_pulse  output  1  one-cycle pulse, high in the cycle after each step.
- lap_done  output  1  one-cycle pulse, coincident with step_pulse, on pattern lap completion.
- lap_count  output  CNT_W  number of completed laps, modulo 2^CNT_W.

## Operation
- Prescaler: counts 0 to TICK_CYCLES-1. A tick is the edge where prescaler == TICK_CYCLES-1 and enable = 1. On a tick the prescaler returns to 0. While enable = 0 it holds its value.
- Reset (reest = 0 at an edge) sets: prescaler = 0; pos = 0; dir = up; mode_q = 00; started = 0; leds = 0; step_pulse = 0; lap_done = 0; lap_count = 0.
- On each tick, if started = 0 or mode != mode_q:
  - mode_q <= mode and started <= 1.
  - The pattern loads its first state: walk-up pos = 0; walk-down pos = NUM_LEDS-1; bounce pos = 0 with dir = up; flash sets all LEDs on.
  - No lap is counted.
- On each tick otherwise, the pattern advances per mode_q:
  - walk-up: pos goes 0 → NUM_LEDS-1, then wraps to 0. The wrap counts as a lap.
  - walk-down: pos goes NUM_LEDS-1 → 0, then wraps to NUM_LEDS-1. The wrap counts as a lap.
  - bounce: pos sequence is 0,1,…,N-1,N-2,…,1,0,1,… Direction reverses on reaching either end. Arrival at 0 from 1 counts as a lap. Period is 2·N-2 ticks.
  - all-flash: LEDs alternate all-on and all-off. The on→off transition counts as a lap.
- leds output:
  - Walk and bounce modes: one-hot, leds[pos] = 1.
  - Flash mode: all ones or all zeros.
- Lap handling:
  - lap_count increments by 1 per lap and wraps from 2^CNT_W-1 to 0.
  - lap_done pulses in the same cycle as lap_count changes.
- mode is sampled only on ticks. Changes between ticks have no effect until the next tick.

## Timing
- After reset release with enable held high:
  - The first tick is at the TICK_CYCLES-th edge.
  - leds, step_pulse and lap_done update at that edge, so there is 1 cycle of latency from the tick condition.
- step_pulse is high for exactly one cycle per tick and low at all other times.
- Steps are separated by exactly TICK_CYCLES cycles while enable stays high.
- A deassertion of enable stretches the step interval by exactly the number of disabled cycles.
- TICK_CYCLES = 1: a tick occurs every enabled cycle, and step_pulse stays high continuously.
- Reset wins over a simultaneous tick. Reset asserted mid-pattern returns everything to its reset values in the next cycle.
- A mode change coincident with the tick that would complete a lap restarts the pattern. No lap is counted.

## Configuration
- LED_SEQ_LAP_COUNT_EN defined: the lap counter, lap_done and the lap-detect logic are built as described above.
- Without the macro: lap_count is tied to 0 and lap_done is tied to 0. The pattern and step_pulse behaviour are unchanged.

## Test plan
All scenarios use NUM_LEDS=3, TICK_CYCLES=4, CNT_W=2 and the macro defined unless stated otherwise.
- Reset then walk-up: release reest, mode=00, enable=1. Required: leds=000 for 3 cycles, then 001/010/100/001 at 4-cycle intervals. lap_done pulses with the 100→001 step, and lap_count=1.
- Bounce: mode=10 for 10 ticks. Required: leds sequence 001,010,100,010,001,010,100,010,001,… and lap_count increments every 4 ticks.
- Lap wrap and flash: mode=11 for 10 ticks. Required: leds alternate 111/000, lap_count sequence goes 1,2,3,0,1, and lap_done is a single-cycle pulse each time.
- Enable stall: drop enable for 5 cycles mid-interval. Required: leds hold, and the next step arrives exactly 5 cycles later than nominal.
- Mode change and mid-run reset:
  - Switch mode 00→01 while leds=010. Required: the next tick shows 100 with lap_count unchanged.
  - Assert reest mid-pattern. Required: all outputs are 0 after the next edge.
- Macro undefined: rerun the walk-up scenario. Required: identical leds and step_pulse; lap_count=0 and lap_done=0 throughout.

Source files
------------

// File: rtl/led_sequencer.sv
// led_sequencer: NUM_LEDS-wide pattern sequencer (walk-up, walk-down, bounce,
// all-flash) stepped by a single free-running prescaler.
// Optional feature macro: LED_SEQ_LAP_COUNT_EN builds the lap detector,
// lap_done pulse and lap_count; without it both outputs are tied to zero.
module led_sequencer #(
  parameter int NUM_LEDS    = 3,
  parameter int TICK_CYCLES = 100000000,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reest,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_pulse,
  output logic                lap_done,
  output logic [CNT_W-1:0]    lap_count
);

  localparam int PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int POSW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [POSW-1:0]     POS_LAST  = POSW'(NUM_LEDS - 1);
  localparam logic [POSW-1:0]     POS_ONE   = POSW'(1);
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_FLASH  = 2'b11
  } mode_e;

  logic [PW-1:0]       presc;
  logic [POSW-1:0]     pos, pos_n;
  logic                dir_down, dir_n;
  logic                flash_on, flash_n;
  logic                started;
  mode_e               mode_q, mode_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic                tick;
  logic                restart;

  assign tick    = enable && (presc == PRESC_MAX);
  // A tick either (re)loads the first state of the sampled pattern or advances it.
  assign restart = !started || (mode != mode_q);

  // Pattern next-state and next LED image, applied only on a tick.
  always_comb begin
    pos_n   = pos;
    dir_n   = dir_down;
    flash_n = flash_on;
    mode_n  = mode_q;
    if (restart) begin
      mode_n  = mode_e'(mode);
      flash_n = 1'b1;
      dir_n   = 1'b0;
      pos_n   = (mode_e'(mode) == M_DOWN) ? POS_LAST : '0;
    end else begin
      case (mode_q)
        M_UP:     pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
        M_DOWN:   pos_n = (pos == '0) ? POS_LAST : pos - 1'b1;
        M_BOUNCE: begin
          // Direction flips on arrival at an end, so N=2 bounces 0,1,0,1.
          if (!dir_down) begin
            pos_n = pos + 1'b1;
            if (pos_n == POS_LAST) dir_n = 1'b1;
          end else begin
            pos_n = pos - 1'b1;
            if (pos_n == '0) dir_n = 1'b0;
          end
        end
        default:  flash_n = !flash_on;
      endcase
    end
    leds_n = (mode_n == M_FLASH) ? {NUM_LEDS{flash_n}} : (LED_ONE << pos_n);
  end

  // Prescaler, pattern state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reest) begin
      presc      <= '0;
      pos        <= '0;
      dir_down   <= 1'b0;
      flash_on   <= 1'b0;
      mode_q     <= M_UP;
      started    <= 1'b0;
      leds       <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= tick;
      if (enable) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        pos      <= pos_n;
        dir_down <= dir_n;
        flash_on <= flash_n;
        mode_q   <= mode_n;
        started  <= 1'b1;
        leds     <= leds_n;
      end
    end
  end

`ifdef LED_SEQ_LAP_COUNT_EN
  logic             lap_hit;
  logic [CNT_W-1:0] lap_cnt_q;
  logic             lap_done_q;

  // The step about to be taken completes a lap; never on a (re)load step.
  always_comb begin
    lap_hit = 1'b0;
    if (!restart) begin
      case (mode_q)
        M_UP:     lap_hit = (pos == POS_LAST);
        M_DOWN:   lap_hit = (pos == '0);
        M_BOUNCE: lap_hit = dir_down && (pos == POS_ONE);
        default:  lap_hit = flash_on;
      endcase
    end
  end

  // Lap counter wraps naturally at 2^CNT_W; pulse aligns with step_pulse.
  always_ff @(posedge clk) begin
    if (!reest) begin
      lap_cnt_q  <= '0;
      lap_done_q <= 1'b0;
    end else begin
      lap_done_q <= tick && lap_hit;
      if (tick && lap_hit) lap_cnt_q <= lap_cnt_q + 1'b1;
    end
  end

  assign lap_count = lap_cnt_q;
  assign lap_done  = lap_done_q;
`else
  assign lap_count = '0;
  assign lap_done  = 1'b0;
`endif

endmodule
